stepper_axis: RTL and testbench

STEPPER_AXIS -- requirements
Module: stepper_axis

---
 rtl/stepper_axis_if.sv | 22 ++
 rtl/stepper_axis.sv | 138 +++++++++++++
 tb/tb_stepper_axis.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/stepper_axis_if.sv
// Move-command handshake bundle for the stepper axis.
// The master offers a command and the slave accepts it with ready.
interface stepper_axis_if #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [DIV_W-1:0] cmd_half;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, cmd_half,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, cmd_half,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_axis.sv
// Single-axis step/dir pulse generator with direction setup time,
// abort handling and a wrapping signed position counter.
module stepper_axis #(
    parameter int CNT_W     = 16,
    parameter int DIV_W     = 8,
    parameter int POS_W     = 32,
    parameter int DIR_SETUP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    stepper_axis_if.slave    cmd,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position
);
    localparam int TMR_W = (DIV_W > 8) ? DIV_W : 8;

    typedef enum logic [2:0] {
        IDLE, SETUP, HIGH, LOW, FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic             dir_q, dir_d;
    logic             abt_q, abt_d;
    logic             step_q, step_d;
    logic             done_q, done_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [TMR_W-1:0] tmr_half;
    logic [POS_W-1:0] pos_inc;

    assign tmr_half = TMR_W'(half_q) - TMR_W'(1);
    // +1 or all-ones (-1) depending on direction
    assign pos_inc  = {{(POS_W-1){~dir_q}}, 1'b1};

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rem_d   = rem_q;
        half_d  = half_q;
        dir_d   = dir_q;
        abt_d   = abt_q;
        pos_d   = pos_q;
        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    half_d = (cmd.cmd_half == '0) ? DIV_W'(1) : cmd.cmd_half;
                    rem_d  = cmd.cmd_steps;
                    abt_d  = 1'b0;
                    if (cmd.cmd_steps == '0) begin
                        state_d = FINISH;
                    end else begin
                        dir_d   = cmd.cmd_dir;
                        tmr_d   = TMR_W'(DIR_SETUP - 1);
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d = FINISH;
                end else if (tmr_q == '0) begin
                    state_d = HIGH;
                    tmr_d   = tmr_half;
                    pos_d   = pos_q + pos_inc;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            HIGH: begin
                // an abort here only takes effect once the pulse is complete
                if (abort) abt_d = 1'b1;
                if (tmr_q == '0) begin
                    state_d = (abort || abt_q) ? FINISH : LOW;
                    tmr_d   = tmr_half;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            LOW: begin
                if (abort) begin
                    state_d = FINISH;
                end else if (tmr_q == '0) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = FINISH;
                    end else begin
                        state_d = HIGH;
                        tmr_d   = tmr_half;
                        pos_d   = pos_q + pos_inc;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        step_d = (state_d == HIGH);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            rem_q   <= '0;
            half_q  <= '0;
            dir_q   <= 1'b0;
            abt_q   <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rem_q   <= rem_d;
            half_q  <= half_d;
            dir_q   <= dir_d;
            abt_q   <= abt_d;
            step_q  <= step_d;
            done_q  <= done_d;
            pos_q   <= pos_d;
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy     = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW);
    assign step     = step_q;
    assign done     = done_q;
    assign dir      = dir_q;
    assign position = pos_q;
endmodule

// File: tb/tb_stepper_axis.sv
// Randomized bench for stepper_axis against a cycle-index waveform model.
// Expected outputs are derived from setup time, half-period and step count.
module tb_stepper_axis;
    localparam int DS    = 2;
    localparam int POS_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             abort = 1'b0;
    logic             step, dir, busy, done;
    logic [POS_W-1:0] position;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [POS_W-1:0] mpos = '0;
    logic             mdir = 1'b0;

    stepper_axis_if #(.CNT_W(16), .DIV_W(8)) cmd_if ();

    stepper_axis #(
        .CNT_W(16), .DIV_W(8), .POS_W(POS_W), .DIR_SETUP(DS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_if.slave), .abort(abort),
        .step(step), .dir(dir), .busy(busy), .done(done),
        .position(position)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ab: cycle index after accept during which abort is held (-1 none)
    task automatic run_cmd(input int n, input bit d, input int half,
                           input int ab, input bit ab_acc);
        int h, e, u, k;
        logic [POS_W-1:0] start, ep;
        logic [4:0] ef;
        logic dv;
        h = (half == 0) ? 1 : half;
        @(negedge clk);
        chk("ready_idle", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_steps = 16'(n);
        cmd_if.cmd_dir   = d;
        cmd_if.cmd_half  = 8'(half);
        abort = ab_acc;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        abort = 1'b0;
        start = mpos;
        ep    = start;
        dv    = (n > 0) ? d : mdir;
        e = (n == 0) ? 0 : DS + 2 * h * n;
        if (n > 0 && ab >= 0 && ab < e) begin
            if (ab < DS) e = ab + 1;
            else begin
                u = ab - DS;
                if ((u % (2 * h)) < h) e = DS + 2 * h * (u / (2 * h)) + h;
                else e = ab + 1;
            end
        end
        for (int c = 0; c <= e + 1; c++) begin
            if (c < e) begin
                if (c < DS) begin
                    ef = {1'b0, 1'b1, 1'b0, 1'b0, dv};
                end else begin
                    u = c - DS;
                    k = u / (2 * h) + 1;
                    ep = d ? start + POS_W'(k) : start - POS_W'(k);
                    ef = {1'b0, 1'b1, 1'b0, ((u % (2 * h)) < h), dv};
                end
            end else if (c == e) begin
                ef = {1'b0, 1'b0, 1'b1, 1'b0, dv};
            end else begin
                ef = {1'b1, 1'b0, 1'b0, 1'b0, dv};
            end
            chk("flags", 32'({cmd_if.cmd_ready, busy, done, step, dir}),
                32'(ef));
            chk("pos", 32'(position), 32'(ep));
            abort = (c == ab);
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        mpos  = ep;
        mdir  = dv;
    endtask

    initial begin
        int n, h, enom, ab;
        bit d, aa;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_steps = '0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_half  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", 32'({busy, done, step, dir}), 32'd0);
        chk("rst_pos", 32'(position), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);

        run_cmd(3, 1'b1, 2, -1, 1'b0);
        chk("pos_after3", 32'(position), 32'd3);
        run_cmd(0, 1'b0, 5, -1, 1'b0);
        run_cmd(3, 1'b0, 1, -1, 1'b0);
        run_cmd(2, 1'b0, 0, -1, 1'b0);
        chk("pos_minus2", 32'(position), 32'hfe);
        run_cmd(4, 1'b1, 4, 10, 1'b0);
        run_cmd(1, 1'b0, 1, -1, 1'b0);
        chk("pos_allones", 32'(position), 32'hff);
        run_cmd(1, 1'b1, 1, -1, 1'b0);
        chk("pos_wrap", 32'(position), 32'd0);
        run_cmd(2, 1'b1, 1, -1, 1'b1);

        for (int i = 0; i < 25; i++) begin
            n = $urandom_range(0, 4);
            h = $urandom_range(0, 3);
            d = 1'($urandom_range(0, 1));
            aa = ($urandom_range(0, 3) == 0);
            enom = DS + 2 * ((h == 0) ? 1 : h) * n;
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, enom) : -1;
            run_cmd(n, d, h, ab, aa);
        end

        // reset in the middle of a LOW phase
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_steps = 16'd3;
        cmd_if.cmd_dir   = 1'b1;
        cmd_if.cmd_half  = 8'd2;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_low", 32'({busy, step}), 32'b10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", 32'({busy, done, step, dir}), 32'd0);
        chk("mid_rst_pos", 32'(position), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("hold_rst", 32'({busy, done, step, position}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mpos = '0;
        mdir = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_done", 32'(done), 32'd0);
        run_cmd(2, 1'b1, 1, -1, 1'b0);
        chk("post_rst_pos", 32'(position), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
